// File: rtl/multdiv_tag_tracker.sv
// Destination-tag tracker for one in-flight multi-cycle multiply/divide op.
// Generates decode hazard stalls and a one-cycle writeback tag pulse on completion.
module multdiv_tag_tracker #(
    parameter int TAG_W          = 5,
    parameter int CNT_W          = 6,
    parameter int TIMEOUT_CYCLES = 40,
    parameter int RSTATUS_TAG    = 30
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_rd,
    input  logic             md_ready,
    input  logic             md_exception,
    input  logic             dec_valid,
    input  logic [TAG_W-1:0] dec_rs1,
    input  logic [TAG_W-1:0] dec_rs2,
    input  logic [TAG_W-1:0] dec_rd,
    output logic             stall,
    output logic             busy,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_rd,
    output logic             wb_exc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [TAG_W-1:0] RSTATUS   = TAG_W'(RSTATUS_TAG);
    localparam logic [CNT_W-1:0] LAST_BUSY = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               wb_valid_q, wb_valid_d;
    logic [TAG_W-1:0]   wb_rd_q, wb_rd_d;
    logic               wb_exc_q, wb_exc_d;
    logic               tag_hit;

    // Next-state and completion logic; IDLE and DONE accept a new issue identically.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        tag_d      = tag_q;
        count_d    = count_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_exc_d   = wb_exc_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (issue_valid) begin
                    tag_d   = issue_rd;
                    count_d = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                count_d = count_q + CNT_W'(1);
                if (md_ready) begin
                    state_d    = DONE;
                    wb_exc_d   = md_exception;
                    wb_rd_d    = md_exception ? RSTATUS : tag_q;
                    // A clean result destined for r0 is dropped.
                    wb_valid_d = md_exception || (tag_q != '0);
                end else if (count_q == LAST_BUSY) begin
                    state_d    = DONE;
                    wb_exc_d   = 1'b1;
                    wb_rd_d    = RSTATUS;
                    wb_valid_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_exc_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_exc_q   <= wb_exc_d;
        end
    end

    // r0 never carries a real dependency, so a zero tag cannot cause a hazard.
    assign tag_hit = dec_valid && (tag_q != '0) &&
                     ((dec_rs1 == tag_q) || (dec_rs2 == tag_q) || (dec_rd == tag_q));

    assign stall    = (state_q == BUSY) && (issue_valid || tag_hit);
    assign busy     = (state_q == BUSY);
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_exc   = wb_exc_q;

endmodule

// File: tb/tb_multdiv_tag_tracker.sv
// Directed bench for multdiv_tag_tracker: stimulus pushes expected writebacks,
// a negedge monitor pops and compares each wb_valid pulse.
module tb_multdiv_tag_tracker;

    typedef struct {
        int rd;
        int exc;
    } wb_exp_t;

    logic       clock;
    logic       ctrl_reset_n;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       md_ready;
    logic       md_exception;
    logic       dec_valid;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic       stall, busy, wb_valid, wb_exc;
    logic [4:0] wb_rd;

    wb_exp_t exp_q[$];
    int      n_cmp  = 0;
    int      n_fail = 0;

    multdiv_tag_tracker dut (
        .clock       (clock),
        .ctrl_reset_n(ctrl_reset_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .md_ready    (md_ready),
        .md_exception(md_exception),
        .dec_valid   (dec_valid),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .stall       (stall),
        .busy        (busy),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_exc      (wb_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int rd, input int exc);
        wb_exp_t e;
        e.rd  = rd;
        e.exc = exc;
        exp_q.push_back(e);
    endtask

    task automatic clear_dec();
        dec_valid = 1'b0;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_rd    = '0;
    endtask

    // Monitor: every writeback pulse must match the oldest expected completion.
    always @(negedge clock) begin
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 1, 0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                check("wb_rd", int'(wb_rd), e.rd);
                check("wb_exc", int'(wb_exc), e.exc);
            end
        end
    end

    initial begin
        ctrl_reset_n = 1'b1;
        issue_valid  = 1'b0;
        issue_rd     = '0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        clear_dec();

        // Reset state
        #2 ctrl_reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_wb_valid", int'(wb_valid), 0);
        check("rst_wb_rd", int'(wb_rd), 0);
        check("rst_wb_exc", int'(wb_exc), 0);
        check("rst_stall", int'(stall), 0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        step();

        // Basic completion with hazard and refused-issue checks (cycle 1 = issue)
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        check("basic_busy_c2", int'(busy), 1);
        dec_valid = 1'b1;
        dec_rs2   = 5'd7;
        #1 check("stall_raw_rs2", int'(stall), 1);
        dec_rs1 = 5'd3;
        dec_rs2 = 5'd4;
        dec_rd  = 5'd5;
        #1 check("stall_no_hit", int'(stall), 0);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1 check("stall_refused_issue", int'(stall), 1);
        step();
        issue_valid = 1'b0;
        dec_rs1 = 5'd9;
        dec_rs2 = '0;
        dec_rd  = '0;
        #1 check("tag_unchanged_9", int'(stall), 0);
        dec_rd = 5'd7;
        #1 check("stall_waw_rd", int'(stall), 1);
        clear_dec();
        step();
        step();
        check("basic_busy_c5", int'(busy), 1);
        md_ready = 1'b1;
        push_exp(7, 0);
        step();
        md_ready = 1'b0;
        check("basic_wb_valid_c6", int'(wb_valid), 1);
        check("basic_busy_c6", int'(busy), 0);
        dec_valid = 1'b1;
        dec_rs1   = 5'd7;
        #1 check("stall_in_done", int'(stall), 0);
        clear_dec();
        step();
        check("basic_wb_valid_c7", int'(wb_valid), 0);
        check("wb_rd_held", int'(wb_rd), 7);
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        check("spurious_idle_busy", int'(busy), 0);

        // Exception completion, then a spurious md_ready in DONE
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        step();
        issue_valid  = 1'b0;
        md_ready     = 1'b1;
        md_exception = 1'b1;
        push_exp(30, 1);
        step();
        md_exception = 1'b0;
        check("exc_wb_valid", int'(wb_valid), 1);
        step();
        md_ready = 1'b0;
        check("spurious_done_busy", int'(busy), 0);
        check("spurious_done_wb", int'(wb_valid), 0);

        // Timeout: 40 BUSY cycles with no md_ready
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        push_exp(30, 1);
        repeat (39) step();
        check("timeout_busy_c40", int'(busy), 1);
        step();
        check("timeout_busy_done", int'(busy), 0);
        check("timeout_wb_valid", int'(wb_valid), 1);
        step();

        // md_ready in the 40th cycle wins over timeout; back-to-back issue in DONE
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        step();
        issue_valid = 1'b0;
        repeat (39) step();
        md_ready = 1'b1;
        push_exp(9, 0);
        step();
        md_ready = 1'b0;
        check("prio_wb_valid", int'(wb_valid), 1);
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
        step();
        issue_valid = 1'b0;
        check("b2b_busy", int'(busy), 1);
        dec_valid = 1'b1;
        dec_rs1   = 5'd4;
        #1 check("b2b_stall_tag4", int'(stall), 1);
        clear_dec();
        md_ready = 1'b1;
        push_exp(4, 0);
        step();
        md_ready = 1'b0;
        step();

        // Zero tag: no hazard, clean r0 result suppressed
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        step();
        issue_valid = 1'b0;
        dec_valid   = 1'b1;
        #1 check("tag0_no_stall", int'(stall), 0);
        clear_dec();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        check("r0_suppressed", int'(wb_valid), 0);
        step();

        // Asynchronous reset mid-operation abandons the op
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        step();
        issue_valid = 1'b0;
        check("midop_busy", int'(busy), 1);
        #2 ctrl_reset_n = 1'b0;
        #1 check("midop_async_busy", int'(busy), 0);
        check("midop_wb_rd", int'(wb_rd), 0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        step();
        md_ready = 1'b1;
        step();
        md_ready = 1'b0;
        #1 check("midop_no_wb", int'(wb_valid), 0);
        step();
        step();

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
